touch_poll_master: RTL
======================

Name: touch_poll_master

Overview:
- Avalon-style read master that sits on the other end of the touch-clip register port (addr 0 = touch count, addr 1 = {x[31:16], y[15:0]}).
- Polls the port periodically, debounces touch presence, and emits press/move/release events with clipped 480x272 coordinates.
- Events go to the waveform UI logic (trigger/cursor control) without needing a soft CPU.

Parameters:
- POLL_DIV, 500000, clk cycles between poll starts (10 ms at 50 MHz); legal range >= 16.
- DEB_CNT, 3, consecutive identical presence samples needed to change the debounced state; legal range 1..15.
- RD_LAT, 1, cycles from the avl_read cycle to valid avl_readdata; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- avl_address  out  3  register address.
- avl_read  out  1  read request, one-cycle pulse.
- avl_write  out  1  constant 0.
- avl_writedata  out  32  constant 0.
- avl_readdata  in  32  read data, valid RD_LAT cycles after avl_read.
- touch_down  out  1  debounced touch state (level).
- touch_x  out  16  last accepted x, 0..479.
- touch_y  out  16  last accepted y, 0..271.
- evt_valid  out  1  one-cycle event strobe.
- evt_type  out  2  01 press, 10 release, 11 move; 00 when evt_valid is 0.
- poll_overrun  out  1  sticky; set when a tick arrives while one is already pending; cleared only by rst.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timer 0; debounce counter 0; pending 0.
- Timer: free-running 0..POLL_DIV-1. A tick is produced at wrap.
  - A tick sets pending.
  - A tick while pending is already 1 is dropped and sets poll_overrun.
- FSM states: IDLE, RD_NUM, WT_NUM, RD_XY, WT_XY, EVAL.
- IDLE: if pending, clear pending and go to RD_NUM.
- RD_NUM: avl_read=1, avl_address=0 for exactly one cycle; go to WT_NUM.
- WT_NUM: wait RD_LAT cycles, then sample readdata[2:0] as num.
  - num != 0: go to RD_XY.
  - num == 0: go to EVAL with raw=0.
- RD_XY: avl_read=1, avl_address=1 for one cycle; go to WT_XY.
- WT_XY: wait RD_LAT cycles, then sample x=readdata[31:16], y=readdata[15:0].
  - If x<480 and y<272: raw=1.
  - Otherwise raw=0 and the coordinates are discarded.
  - Go to EVAL.
- EVAL (single cycle, then IDLE):
  - raw == touch_down: debounce counter cleared.
  - raw != touch_down: counter increments. When it reaches DEB_CNT, touch_down toggles and the counter clears.
  - A 0->1 toggle emits press and loads touch_x/touch_y.
  - A 1->0 toggle emits release; touch_x/touch_y hold.
  - touch_down already 1, raw=1, and (x,y) differs from touch_x/touch_y: emit move and load the new x/y.
- evt_valid is asserted in the cycle after EVAL, for exactly one cycle. At most one event per poll.
- avl_address holds its last value when avl_read=0. avl_read is never asserted in two consecutive cycles.
- Worst-case poll length: 2*(1+RD_LAT)+2 cycles, which is less than POLL_DIV, so overrun occurs only under misconfiguration.
- Reset mid-transaction: avl_read and evt_valid drop asynchronously. Any in-flight readdata is ignored after release.
- DEB_CNT=1: the state changes on the first differing sample.

Decomposition:
- Shared package touch_pkg holds:
  - constants TP_ADDR_NUM=3'd0, TP_ADDR_XY=3'd1, TP_W=480, TP_H=272;
  - EVT_PRESS/EVT_RELEASE/EVT_MOVE encodings;
  - FSM state enum.
- One natural sub-module: touch_debounce, containing the counter, the touch_down register and event classification, driven by a sample strobe plus raw/x/y.
- Timer and FSM stay in the top module.

Test Plan:
Bench uses POLL_DIV=32, DEB_CNT=3, RD_LAT=1 unless stated, with a slave model that has registered readdata.
- Reset, no stimulus for 200 cycles -> avl_read pulses every 32 cycles at address 0 only; evt_valid never asserted; touch_down=0.
- Slave returns num=1, xy=(100,50) for 3 polls -> exactly one press event after the 3rd poll; touch_x=100, touch_y=50; touch_down=1; address 1 read on each poll.
- Hold touch, change xy to (101,50) -> one move event, touch_x=101. Next poll with the same xy -> no event.
- num=0 for 2 polls, then num=1 for 1 poll, then num=0 for 3 polls -> no release until the 3rd consecutive zero; then release with touch_x/touch_y unchanged.
- num=1, xy=(480,10) for 5 polls while idle -> no press (off-screen treated as no touch); touch_x stays 0.
- Assert rst during RD_XY -> avl_read=0 immediately. After release, the first read is at address 0, 32 cycles later. RD_LAT=3 variant: same press timing, offset by 2 cycles per read.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared constants, event encodings and FSM states for the touch poll master.
package touch_pkg;
    localparam logic [2:0] TP_ADDR_NUM = 3'd0;
    localparam logic [2:0] TP_ADDR_XY  = 3'd1;
    localparam int         TP_W        = 480;
    localparam int         TP_H        = 272;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_MOVE    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_NUM,
        WT_NUM,
        RD_XY,
        WT_XY,
        EVAL
    } tp_state_t;
endpackage

// File: rtl/touch_poll_master_if.sv
// Avalon-MM read master bus towards the touch-clip register port.
interface touch_poll_master_if;
    logic [2:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata,
        output avl_readdata
    );
endinterface

// File: rtl/touch_debounce.sv
// Debounces raw touch presence and classifies press/move/release events.
module touch_debounce
    import touch_pkg::*;
#(
    parameter int DEB_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic        raw,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        touch_down,
    output logic [15:0] touch_x,
    output logic [15:0] touch_y,
    output logic        evt_valid,
    output logic [1:0]  evt_type
);

    logic [3:0] cnt;

    // One evaluation per sample strobe; the event strobe lands the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            touch_down <= 1'b0;
            touch_x    <= '0;
            touch_y    <= '0;
            evt_valid  <= 1'b0;
            evt_type   <= EVT_NONE;
        end else begin
            evt_valid <= 1'b0;
            evt_type  <= EVT_NONE;
            if (sample) begin
                if (raw == touch_down) begin
                    cnt <= '0;
                    // Still touching: report a move only if the position changed.
                    if (touch_down && (x != touch_x || y != touch_y)) begin
                        touch_x   <= x;
                        touch_y   <= y;
                        evt_valid <= 1'b1;
                        evt_type  <= EVT_MOVE;
                    end
                end else if (cnt + 4'd1 == 4'(DEB_CNT)) begin
                    cnt        <= '0;
                    touch_down <= raw;
                    evt_valid  <= 1'b1;
                    if (raw) begin
                        touch_x  <= x;
                        touch_y  <= y;
                        evt_type <= EVT_PRESS;
                    end else begin
                        evt_type <= EVT_RELEASE;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/touch_poll_master.sv
// Periodic poller of the touch-clip port: timer, read FSM and debounce.
module touch_poll_master
    import touch_pkg::*;
#(
    parameter int POLL_DIV = 500000,
    parameter int DEB_CNT  = 3,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    touch_poll_master_if.master bus,
    output logic                touch_down,
    output logic [15:0]         touch_x,
    output logic [15:0]         touch_y,
    output logic                evt_valid,
    output logic [1:0]          evt_type,
    output logic                poll_overrun
);

    localparam int TW = $clog2(POLL_DIV);

    tp_state_t   state, state_nx;
    logic [TW-1:0] timer;
    logic        tick, pending, pend_clr;
    logic [1:0]  wcnt;
    logic        lat_done;
    logic [2:0]  addr_q;
    logic        raw_q;
    logic [15:0] x_q, y_q;
    logic [15:0] rd_x, rd_y;
    logic        in_range;

    assign tick     = (timer == TW'(POLL_DIV - 1));
    assign lat_done = (wcnt == 2'(RD_LAT - 1));
    assign rd_x     = bus.avl_readdata[31:16];
    assign rd_y     = bus.avl_readdata[15:0];
    assign in_range = (rd_x < 16'(TP_W)) && (rd_y < 16'(TP_H));

    assign bus.avl_address   = addr_q;
    assign bus.avl_write     = 1'b0;
    assign bus.avl_writedata = '0;

    // Free-running poll interval timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer <= '0;
        else if (tick) timer <= '0;
        else timer <= timer + TW'(1);
    end

    // Pending poll request; a tick landing on an unconsumed request is an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 1'b0;
            poll_overrun <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
            if (pending && !pend_clr) poll_overrun <= 1'b1;
        end else if (pend_clr) begin
            pending <= 1'b0;
        end
    end

    // Next state and read strobe; avl_read is combinational so reset kills it at once.
    always_comb begin
        state_nx     = state;
        bus.avl_read = 1'b0;
        pend_clr     = 1'b0;
        case (state)
            IDLE: if (pending) begin
                pend_clr = 1'b1;
                state_nx = RD_NUM;
            end
            RD_NUM: begin
                bus.avl_read = 1'b1;
                state_nx     = WT_NUM;
            end
            WT_NUM: if (lat_done) state_nx = (bus.avl_readdata[2:0] != 3'd0) ? RD_XY : EVAL;
            RD_XY: begin
                bus.avl_read = 1'b1;
                state_nx     = WT_XY;
            end
            WT_XY:   if (lat_done) state_nx = EVAL;
            EVAL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, latency counter, held address and captured sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            addr_q <= TP_ADDR_NUM;
            raw_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (state == WT_NUM || state == WT_XY) ? wcnt + 2'd1 : 2'd0;
            if (state_nx == RD_NUM)     addr_q <= TP_ADDR_NUM;
            else if (state_nx == RD_XY) addr_q <= TP_ADDR_XY;
            if (state == WT_NUM && lat_done && bus.avl_readdata[2:0] == 3'd0) raw_q <= 1'b0;
            if (state == WT_XY && lat_done) begin
                raw_q <= in_range;
                x_q   <= rd_x;
                y_q   <= rd_y;
            end
        end
    end

    touch_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk        (clk),
        .rst        (rst),
        .sample     (state == EVAL),
        .raw        (raw_q),
        .x          (x_q),
        .y          (y_q),
        .touch_down (touch_down),
        .touch_x    (touch_x),
        .touch_y    (touch_y),
        .evt_valid  (evt_valid),
        .evt_type   (evt_type)
    );

endmodule
